mod_n_cascade_counter: RTL and testbench

- Parametrised successor to the single-digit mod-10 counters: a chain of DIGITS mod-MOD digit stages, giving a counter modulo MOD^DIGITS. The default is two BCD digits, i.e. a mod-100 counter.
- Adds enable, up/down direction, synchronous clear, validated parallel load, a wrap/saturate mode, a terminal-count flag and a registered wrap pulse.
- Used as the timebase/event counter in the counter designs and their benches.

---
 rtl/mod_n_cascade_counter.sv | 119 +++++++++++
 tb/tb_mod_n_cascade_counter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_cascade_counter.sv
// +--------------------------------------------------------------------------+
// | mod_n_cascade_counter                                                    |
// | DIGITS cascaded mod-MOD digit stages: up/down, clear, validated load,    |
// | wrap or saturate at terminal value. Optional `MOD_N_WRAP_CNT_EN adds an  |
// | 8-bit wrap event counter output (wrap_cnt).                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mod_n_cascade_counter #(
  parameter int MOD      = 10,
  parameter int DIGITS   = 2,
  parameter int SATURATE = 0,
  parameter int DW       = $clog2(MOD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 wrap,
`ifdef MOD_N_WRAP_CNT_EN
  output logic                 load_err,
  output logic [7:0]           wrap_cnt
`else
  output logic                 load_err
`endif
);

  localparam logic [DW-1:0] c_max = DW'(MOD - 1);
  localparam logic [DW:0]   c_mod = (DW+1)'(MOD);

  logic [DIGITS*DW-1:0] r_count;
  logic                 r_wrap;
  logic                 r_load_err;

  // w_carry[i] is the step request arriving at digit i; digit 0 always steps.
  logic [DIGITS:0]      w_carry;
  logic [DIGITS*DW-1:0] w_step;
  logic [DIGITS-1:0]    w_digit_ok;
  logic                 w_load_ok;
  logic                 w_hold;
  logic                 w_wrap_evt;

  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DW-1:0] w_d;
    logic [DW-1:0] w_lv;
    logic [DW-1:0] w_next;

    assign w_d  = r_count[i*DW +: DW];
    assign w_lv = load_val[i*DW +: DW];

    assign w_carry[i+1] = w_carry[i] & (up_dn ? (w_d == c_max) : (w_d == '0));

    assign w_next = !w_carry[i] ? w_d :
                    up_dn       ? ((w_d == c_max) ? '0 : w_d + 1'b1) :
                                  ((w_d == '0) ? c_max : w_d - 1'b1);

    assign w_step[i*DW +: DW] = w_next;
    assign w_digit_ok[i]      = ({1'b0, w_lv} < c_mod);
  end

  // Every digit at its end value for the current direction is the terminal count.
  assign tc         = w_carry[DIGITS];
  assign w_load_ok  = &w_digit_ok;
  assign w_hold     = (SATURATE != 0) && tc;
  assign w_wrap_evt = !clr && !load && en && !w_hold && tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_wrap_evt;
      r_load_err <= 1'b0;
      if (clr) begin
        r_count <= '0;
      end else if (load) begin
        if (w_load_ok) begin
          r_count <= load_val;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (en && !w_hold) begin
        r_count <= w_step;
      end
    end
  end

`ifdef MOD_N_WRAP_CNT_EN
  logic [7:0] r_wrap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap_cnt <= '0;
    end else if (clr) begin
      r_wrap_cnt <= '0;
    end else if (w_wrap_evt) begin
      r_wrap_cnt <= r_wrap_cnt + 8'd1;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_mod_n_cascade_counter.sv
// Bench for mod_n_cascade_counter: a wrapping and a saturating instance (MOD=10,
// DIGITS=2) share stimulus and are compared against an integer-valued model.
`default_nettype none

module tb_mod_n_cascade_counter;

  localparam int MOD    = 10;
  localparam int DIGITS = 2;
  localparam int DW     = 4;
  localparam int NVAL   = 100;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en, up_dn, clr, load;
  logic [DIGITS*DW-1:0] load_val;
  logic [DIGITS*DW-1:0] count0, count1;
  logic                 tc0, tc1, wrap0, wrap1, lerr0, lerr1;
`ifdef MOD_N_WRAP_CNT_EN
  logic [7:0]           wcnt0, wcnt1;
`endif

  int checks = 0;
  int errors = 0;

  int m_v  [2];
  bit m_wrap[2];
  bit m_lerr[2];
  int m_wc [2];

  always #5 clk = ~clk;

  mod_n_cascade_counter #(.MOD(MOD), .DIGITS(DIGITS), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(count0), .tc(tc0), .wrap(wrap0),
`ifdef MOD_N_WRAP_CNT_EN
    .load_err(lerr0), .wrap_cnt(wcnt0)
`else
    .load_err(lerr0)
`endif
  );

  mod_n_cascade_counter #(.MOD(MOD), .DIGITS(DIGITS), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(count1), .tc(tc1), .wrap(wrap1),
`ifdef MOD_N_WRAP_CNT_EN
    .load_err(lerr1), .wrap_cnt(wcnt1)
`else
    .load_err(lerr1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DIGITS*DW-1:0] pack(input int v);
    logic [DIGITS*DW-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DW +: DW] = DW'((v / p) % MOD);
      p = p * MOD;
    end
    return r;
  endfunction

  // Returns the integer value of a load word, or -1 if any digit is out of range.
  function automatic int decode(input logic [DIGITS*DW-1:0] lv);
    int v, p, d;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[i*DW +: DW]);
      if (d >= MOD) return -1;
      v = v + d * p;
      p = p * MOD;
    end
    return v;
  endfunction

  function automatic bit term(input int v, input bit up);
    return up ? (v == NVAL - 1) : (v == 0);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_v[s] = 0; m_wrap[s] = 0; m_lerr[s] = 0; m_wc[s] = 0;
    end
  endfunction

  // Instance 1 saturates; instance 0 wraps.
  function automatic void model_step();
    for (int s = 0; s < 2; s++) begin
      bit t;
      int lvv;
      m_wrap[s] = 0;
      m_lerr[s] = 0;
      if (clr) begin
        m_v[s]  = 0;
        m_wc[s] = 0;
      end else if (load) begin
        lvv = decode(load_val);
        if (lvv >= 0) m_v[s] = lvv;
        else          m_lerr[s] = 1;
      end else if (en) begin
        t = term(m_v[s], up_dn);
        if (!(t && s == 1)) begin
          m_v[s]    = up_dn ? (m_v[s] + 1) % NVAL : (m_v[s] + NVAL - 1) % NVAL;
          m_wrap[s] = t;
          if (t) m_wc[s] = (m_wc[s] + 1) % 256;
        end
      end
    end
  endfunction

  task automatic compare();
    check("count_w", 32'(count0), 32'(pack(m_v[0])));
    check("count_s", 32'(count1), 32'(pack(m_v[1])));
    check("wrap_w",  32'(wrap0),  32'(m_wrap[0]));
    check("wrap_s",  32'(wrap1),  32'(m_wrap[1]));
    check("lerr_w",  32'(lerr0),  32'(m_lerr[0]));
    check("lerr_s",  32'(lerr1),  32'(m_lerr[1]));
    check("tc_w",    32'(tc0),    32'(term(m_v[0], up_dn)));
    check("tc_s",    32'(tc1),    32'(term(m_v[1], up_dn)));
`ifdef MOD_N_WRAP_CNT_EN
    check("wcnt_w",  32'(wcnt0),  32'(m_wc[0]));
    check("wcnt_s",  32'(wcnt1),  32'(m_wc[1]));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic set_in(input bit c, input bit l, input bit e, input bit u,
                        input logic [DIGITS*DW-1:0] lv);
    clr = c; load = l; en = e; up_dn = u; load_val = lv;
  endtask

  typedef struct {
    bit                   clr, load, en, up;
    logic [DIGITS*DW-1:0] lv;
    logic [DIGITS*DW-1:0] cnt;
    bit                   wrap, lerr, tc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int nwrap, ntc;

    vecs[0]  = '{0, 1, 0, 1, 8'h5A, 8'h00, 0, 1, 0};
    vecs[1]  = '{0, 1, 0, 1, 8'h47, 8'h47, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 1, 8'h00, 8'h48, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 0, 8'h00, 8'h47, 0, 0, 0};
    vecs[4]  = '{1, 1, 1, 1, 8'h12, 8'h00, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 8'h00, 8'h99, 1, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 8'h00, 8'h98, 0, 0, 0};
    vecs[7]  = '{0, 1, 1, 1, 8'h99, 8'h99, 0, 0, 1};
    vecs[8]  = '{0, 0, 1, 1, 8'h00, 8'h00, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1};
    vecs[10] = '{0, 1, 0, 0, 8'h9F, 8'h00, 0, 1, 1};
    vecs[11] = '{0, 1, 0, 0, 8'hA0, 8'h00, 0, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1};

    rst_n = 1'b0;
    set_in(0, 0, 0, 1, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
      step();
      check($sformatf("vec%0d.count", i), 32'(count0), 32'(vecs[i].cnt));
      check($sformatf("vec%0d.wrap", i),  32'(wrap0),  32'(vecs[i].wrap));
      check($sformatf("vec%0d.lerr", i),  32'(lerr0),  32'(vecs[i].lerr));
      check($sformatf("vec%0d.tc", i),    32'(tc0),    32'(vecs[i].tc));
    end

    // Full up-count lap from reset.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 1, 1, '0);
    nwrap = 0;
    ntc   = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      nwrap += int'(wrap0);
      ntc   += int'(tc0);
    end
    check("lap_count", 32'(count0), 32'h00);
    check("lap_wraps", 32'(nwrap), 32'd1);
    check("lap_tc",    32'(ntc),   32'd1);

    // Saturating instance holds at the top, then steps down immediately.
    set_in(0, 1, 0, 1, 8'h98);
    step();
    set_in(0, 0, 1, 1, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("sat_hold",  32'(count1), 32'h99);
      check("sat_nowrap", 32'(wrap1), 32'd0);
    end
    up_dn = 1'b0;
    step();
    check("sat_down", 32'(count1), 32'h98);

`ifdef MOD_N_WRAP_CNT_EN
    set_in(1, 0, 0, 1, '0);
    step();
    set_in(0, 0, 1, 1, '0);
    repeat (250) step();
    check("wcnt_250", 32'(wcnt0), 32'd2);
    set_in(1, 0, 0, 1, '0);
    step();
    check("wcnt_clr", 32'(wcnt0), 32'd0);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [DIGITS*DW-1:0] lv;
      if ($urandom_range(0, 3) == 0) lv = DIGITS*DW'($urandom);
      else lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      set_in($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, lv);
      step();
    end

    // Asynchronous reset mid-count takes effect before any clock edge.
    set_in(0, 1, 0, 1, 8'h52);
    step();
    set_in(0, 0, 0, 1, '0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_w", 32'(count0), 32'h00);
    check("async_rst_s", 32'(count1), 32'h00);
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 1, 1, '0);
    step();
    check("post_rst", 32'(count0), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
